// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_ADC   = 4'h2;
    localparam logic [3:0] OP_SBB   = 4'h3;
    localparam logic [3:0] OP_DIVU  = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h8;
    localparam logic [3:0] OP_OR    = 4'h9;
    localparam logic [3:0] OP_XOR   = 4'hA;
    localparam logic [3:0] OP_NOTB  = 4'hB;
    localparam logic [3:0] OP_PASSA = 4'hC;
    localparam logic [3:0] OP_NOTA  = 4'hD;
    localparam logic [3:0] OP_ZERO  = 4'hE;
    localparam logic [3:0] OP_ONE   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int unsigned FLAG_OVF   = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_ZERO  = 2;
    localparam int unsigned FLAG_ERR   = 3;

endpackage

// File: rtl/alu_seq_divstep.sv
// Combinational restoring-divide step resolving SLICE quotient bits.
module alu_seq_divstep
    import alu_seq_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned SLICE = 1
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0]   r;
    logic [W-1:0] q;

    // rem < divisor on entry, so the shifted remainder always fits in W+1 bits
    always_comb begin
        r = {1'b0, rem_i};
        q = quo_i;
        for (int i = 0; i < int'(SLICE); i++) begin
            r = {r[W-1:0], q[W-1]};
            q = {q[W-2:0], 1'b0};
            if (r >= {1'b0, div_i}) begin
                r    = r - {1'b0, div_i};
                q[0] = 1'b1;
            end
        end
        rem_o = r[W-1:0];
        quo_o = q;
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus optional multi-cycle
// unsigned divider compiled in with ALU_SEQ_DIV_EN.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned SLICE = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [3:0]   INST,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] Z,
    output logic [W-1:0] R,
    output logic [3:0]   FLAGS
);

    if (W < 8 || W > 64 || (SLICE != 1 && SLICE != 2) || (W % SLICE) != 0) begin : g_param_err
        $error("alu_seq: illegal W/SLICE combination");
    end

    logic [W-1:0] z_q, z_d, r_q, r_d;
    logic [3:0]   flags_q, flags_d;
    logic         done_q, done_d;
    logic         carry_q, carry_d;
    logic         take_c;

    logic         sub_c, cin_c, op_arith_c, op_err_c;
    logic [W-1:0] b_op_c, op_z_c, op_r_c;
    logic [W:0]   sum_c;
    logic [3:0]   op_flags_c;

    // One shared adder: subtract variants use A + ~B + cin
    assign sub_c  = (INST == OP_SUB) || (INST == OP_SBB);
    assign cin_c  = (INST == OP_ADD) ? 1'b0 : (INST == OP_SUB) ? 1'b1 : carry_q;
    assign b_op_c = sub_c ? ~B : B;
    assign sum_c  = {1'b0, A} + {1'b0, b_op_c} + {{W{1'b0}}, cin_c};

    always_comb begin : op_decode
        op_z_c     = '0;
        op_r_c     = '0;
        op_err_c   = 1'b0;
        op_arith_c = 1'b0;
        op_flags_c = '0;
        case (INST)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
                op_arith_c = 1'b1;
                op_z_c     = sum_c[W-1:0];
            end
            OP_AND:   op_z_c = A & B;
            OP_OR:    op_z_c = A | B;
            OP_XOR:   op_z_c = A ^ B;
            OP_NOTB:  op_z_c = ~B;
            OP_PASSA: op_z_c = A;
            OP_NOTA:  op_z_c = ~A;
            OP_ZERO:  op_z_c = '0;
            OP_ONE:   op_z_c = W'(1);
`ifdef ALU_SEQ_DIV_EN
            // Only reached as a single-cycle op for a zero divisor
            OP_DIVU: begin
                op_z_c   = '1;
                op_r_c   = A;
                op_err_c = 1'b1;
            end
`endif
            default:  op_err_c = 1'b1;
        endcase
        if (op_err_c) begin
            op_flags_c[FLAG_ERR] = 1'b1;
        end else begin
            op_flags_c[FLAG_ZERO] = (op_z_c == '0);
            if (op_arith_c) begin
                op_flags_c[FLAG_CARRY] = sum_c[W];
                op_flags_c[FLAG_OVF]   = (A[W-1] == b_op_c[W-1]) && (sum_c[W-1] != A[W-1]);
            end
        end
    end

`ifdef ALU_SEQ_DIV_EN
    localparam int unsigned STEPS = W / SLICE;
    localparam int unsigned CW    = $clog2(STEPS);

    state_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [W-1:0] step_rem_c, step_quo_c;
    logic         busy_q, busy_d;

    alu_seq_divstep #(
        .W     (W),
        .SLICE (SLICE)
    ) u_divstep (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem_c),
        .quo_o (step_quo_c)
    );
`endif

    always_comb begin : next_state
        z_d     = z_q;
        r_d     = r_q;
        flags_d = flags_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        take_c  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (INST == OP_DIVU && B != '0) begin
                        state_d = DIV;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = A;
                        dvs_d   = B;
                    end else begin
                        take_c = 1'b1;
                    end
                end
            end
            DIV: begin
                rem_d = step_rem_c;
                quo_d = step_quo_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d             = FIN;
                    z_d                 = step_quo_c;
                    r_d                 = step_rem_c;
                    flags_d             = '0;
                    flags_d[FLAG_ZERO]  = (step_quo_c == '0);
                    done_d              = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
`else
        take_c = START;
`endif
        if (take_c) begin
            z_d     = op_z_c;
            r_d     = op_r_c;
            flags_d = op_flags_c;
            done_d  = 1'b1;
            if (op_arith_c) begin
                carry_d = sum_c[W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            z_q     <= '0;
            r_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
`endif
        end else begin
            z_q     <= z_d;
            r_q     <= r_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            carry_q <= carry_d;
`ifdef ALU_SEQ_DIV_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
`endif
        end
    end

    assign Z     = z_q;
    assign R     = r_q;
    assign FLAGS = flags_q;
    assign DONE  = done_q;
`ifdef ALU_SEQ_DIV_EN
    assign BUSY  = busy_q;
`else
    assign BUSY  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (W=32, SLICE=1); divider
// sequences run only when ALU_SEQ_DIV_EN is defined.
module tb_alu_seq;

    logic        CLK, RST, START, BUSY, DONE;
    logic [3:0]  INST, FLAGS;
    logic [31:0] A, B, Z, R;

    int total = 0;
    int bad   = 0;

    alu_seq #(.W(32), .SLICE(1)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .INST  (INST),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .Z     (Z),
        .R     (R),
        .FLAGS (FLAGS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // START sampled at the next edge; returns #1 into cycle T+1
    task automatic issue(input logic [3:0] inst, input logic [31:0] a, input logic [31:0] b);
        START = 1'b1;
        INST  = inst;
        A     = a;
        B     = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        issue(v.inst, v.a, v.b);
        chk({tag, "_done"},  64'(DONE),  64'd1);
        chk({tag, "_busy"},  64'(BUSY),  64'd0);
        chk({tag, "_z"},     64'(Z),     64'(v.z));
        chk({tag, "_r"},     64'(R),     64'(v.r));
        chk({tag, "_flags"}, 64'(FLAGS), 64'(v.f));
        @(posedge CLK);
        #1;
        chk({tag, "_done_low"}, 64'(DONE), 64'd0);
        chk({tag, "_z_hold"},   64'(Z),    64'(v.z));
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

`ifdef ALU_SEQ_DIV_EN
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ez,
                           input logic [31:0] er, input logic [3:0] ef, input logic [31:0] prev_z);
        int          busy_n;
        int          done_n;
        int          done_at;
        logic [31:0] cz;
        logic [31:0] cr;
        logic [3:0]  cf;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        cz = '0;
        cr = '0;
        cf = '0;
        issue(4'h6, a, b);
        for (int k = 1; k <= 40; k++) begin
            if (BUSY) busy_n++;
            if (DONE) begin
                done_n++;
                done_at = k;
                cz = Z;
                cr = R;
                cf = FLAGS;
            end
            if (k == 10) chk("div_mid_z_hold", 64'(Z), 64'(prev_z));
            // stray STARTs mid-divide and in the FIN cycle must be ignored
            START = (k == 5 || k == 33);
            INST  = 4'hF;
            A     = 32'h5;
            B     = 32'h5;
            @(posedge CLK);
            #1;
        end
        START = 1'b0;
        chk("div_busy_cycles", 64'(busy_n),  64'd33);
        chk("div_done_count",  64'(done_n),  64'd1);
        chk("div_done_cycle",  64'(done_at), 64'd33);
        chk("div_z",           64'(cz),      64'(ez));
        chk("div_r",           64'(cr),      64'(er));
        chk("div_flags",       64'(cf),      64'(ef));
        chk("div_z_after",     64'(Z),       64'(ez));
    endtask
`endif

    initial begin
        vec_t v;
        int   done_n;

        RST   = 1'b1;
        START = 1'b0;
        INST  = 4'h0;
        A     = '0;
        B     = '0;

        vecs[0]  = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b0110};
        vecs[1]  = '{4'h2, 32'h00000000, 32'h00000000, 32'h00000001, 32'h0, 4'b0000};
        vecs[2]  = '{4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 4'b0011};
        vecs[3]  = '{4'h3, 32'h00000005, 32'h00000003, 32'h00000002, 32'h0, 4'b0010};
        vecs[4]  = '{4'h2, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 32'h0, 4'b0001};
        vecs[5]  = '{4'h3, 32'h00000005, 32'h00000003, 32'h00000001, 32'h0, 4'b0010};
        vecs[6]  = '{4'h8, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 4'b0000};
        vecs[7]  = '{4'h9, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 32'h0, 4'b0000};
        vecs[8]  = '{4'hA, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000000, 32'h0, 4'b0100};
        vecs[9]  = '{4'hB, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'h0, 4'b0100};
        vecs[10] = '{4'hC, 32'h12345678, 32'h00000000, 32'h12345678, 32'h0, 4'b0000};
        vecs[11] = '{4'hD, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 4'b0000};
        vecs[12] = '{4'hE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 4'b0100};
        vecs[13] = '{4'hF, 32'h00000000, 32'h00000000, 32'h00000001, 32'h0, 4'b0000};
        vecs[14] = '{4'h4, 32'h00000001, 32'h00000001, 32'h00000000, 32'h0, 4'b1000};
        vecs[15] = '{4'h7, 32'h00000001, 32'h00000001, 32'h00000000, 32'h0, 4'b1000};
        vecs[16] = '{4'h2, 32'h00000000, 32'h00000000, 32'h00000001, 32'h0, 4'b0000};
        vecs[17] = '{4'h1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0, 4'b0000};
        vecs[18] = '{4'h2, 32'h00000001, 32'h00000001, 32'h00000002, 32'h0, 4'b0000};
`ifdef ALU_SEQ_DIV_EN
        vecs[19] = '{4'h6, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'h1234, 4'b1000};
`else
        vecs[19] = '{4'h6, 32'h00000064, 32'h00000007, 32'h00000000, 32'h0, 4'b1000};
`endif

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_busy",  64'(BUSY),  64'd0);
        chk("rst_done",  64'(DONE),  64'd0);
        chk("rst_z",     64'(Z),     64'd0);
        chk("rst_r",     64'(R),     64'd0);
        chk("rst_flags", 64'(FLAGS), 64'd0);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef ALU_SEQ_DIV_EN
        run_div(32'd100,      32'd7,  32'd14,        32'd2,  4'b0000, 32'hFFFFFFFF);
        run_div(32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF,  32'hF,  4'b0000, 32'd14);
        run_div(32'd3,        32'd5,  32'd0,         32'd3,  4'b0100, 32'h0FFFFFFF);

        // reset during a divide aborts it
        issue(4'h6, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge CLK);
            #1;
        end
        pulse_reset();
        chk("abort_busy",  64'(BUSY),  64'd0);
        chk("abort_done",  64'(DONE),  64'd0);
        chk("abort_z",     64'(Z),     64'd0);
        chk("abort_flags", 64'(FLAGS), 64'd0);
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (DONE || BUSY) done_n++;
            @(posedge CLK);
            #1;
        end
        chk("abort_no_done", 64'(done_n), 64'd0);
`endif

        v = '{4'hA, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0, 32'h0, 4'b0100};
        run_vec(v, "xor_after_abort");

        // reset wins over a simultaneous START
        v = '{4'hF, 32'h0, 32'h0, 32'h1, 32'h0, 4'b0000};
        run_vec(v, "one_before_rst");
        RST   = 1'b1;
        START = 1'b1;
        INST  = 4'hD;
        A     = 32'h0;
        B     = 32'h0;
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        START = 1'b0;
        chk("rst_start_done",  64'(DONE),  64'd0);
        chk("rst_start_z",     64'(Z),     64'd0);
        chk("rst_start_flags", 64'(FLAGS), 64'd0);

        // stored carry cleared by reset
        v = '{4'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'b0110};
        run_vec(v, "carry_set");
        pulse_reset();
        v = '{4'h2, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0100};
        run_vec(v, "adc_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
